instr_stream_responder: RTL
===========================

Name: instr_stream_responder

Overview:
- Responder end of the syn/ack/last instruction-streaming handshake.
- Holds a loadable program memory and, while the requester's syn is high, returns one instruction per cycle.
- Each returned word is qualified by ack; the final word of the programmed length is flagged with last.
- Sits between the program loader (testbench or boot logic) and the instruction-fetch stage that drives f_i_syn.

Parameters:
- IWIDTH, 32, instruction width in bits.
- DEPTH, 5, address width; memory holds 2^DEPTH words (32).

Ports:
- f_clk  input  1  clock, rising edge.
- f_rst  input  1  reset, asynchronous, active-low.
- f_i_syn  input  1  stream request from fetch stage; high = send next word.
- f_o_instr  output  IWIDTH  instruction word; valid only when f_o_ack=1, else 0.
- f_o_ack  output  1  word valid this cycle.
- f_o_last  output  1  final word of program; asserted only together with f_o_ack.
- f_i_wr_en  input  1  program-memory write strobe.
- f_i_wr_addr  input  DEPTH  write address.
- f_i_wr_data  input  IWIDTH  write data.
- f_i_len  input  DEPTH+1  program length in words, 1..2^DEPTH; sampled at stream start.
- f_o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (f_rst=0, async):
  - State IDLE, rd_ptr=0, len_q=0.
  - f_o_instr=0, f_o_ack=0, f_o_last=0, f_o_busy=0.
  - Memory contents are NOT reset; a reset mid-stream aborts the stream and preserves memory.
- States: IDLE, STREAM, DONE. All outputs are registered.
- IDLE:
  - f_i_syn=1 and f_i_len!=0: latch len_q=f_i_len, rd_ptr=0, go to STREAM. No ack in this cycle.
  - f_i_syn=1 and f_i_len=0: stay IDLE, never ack.
  - f_i_len > 2^DEPTH is clamped to 2^DEPTH.
- STREAM, per edge with f_i_syn=1:
  - f_o_instr=mem[rd_ptr], f_o_ack=1, f_o_last=(rd_ptr==len_q-1), rd_ptr++.
  - On the last beat, go to DONE.
- STREAM, per edge with f_i_syn=0:
  - f_o_ack=0, f_o_last=0, f_o_instr=0; rd_ptr holds (pause).
  - Resume continues from rd_ptr with no repeated or skipped word.
- Latency:
  - First ack appears 2 edges after f_i_syn is first sampled high (IDLE->STREAM edge, then the data edge).
  - Afterwards, 1 word per cycle while syn stays high.
- DONE:
  - f_o_ack=0, f_o_last=0, f_o_instr=0.
  - Wait for f_i_syn=0, then go to IDLE. This prevents replay while the requester's registered syn is still falling.
- Writes:
  - f_i_wr_en=1 in IDLE or DONE: mem[f_i_wr_addr] <= f_i_wr_data.
  - A write at the IDLE->STREAM edge is committed before the first read.
  - Writes in STREAM are ignored (memory unchanged).
- Wrap: rd_ptr is DEPTH+1 bits internally; len_q=2^DEPTH streams addresses 0..31 with no aliasing.
- Simultaneous last beat and syn drop: last beat already registered, so the DONE transition is unaffected.
- f_o_last never asserts without f_o_ack.

Decomposition:
- Shared package (stream_pkg): state encoding constants (IDLE/STREAM/DONE) and IWIDTH/DEPTH defaults, for reuse by instruction_fetch and the bench.
- Sub-module instr_mem:
  - Write port: synchronous write, one port.
  - Read port: asynchronous read, one port.
  - No reset.
  - The responder FSM and pointer logic stay in the top module.

Test Plan:
- Reset mid-stream: load words 0..3, len=4, syn high, assert f_rst low after 2 acks -> all outputs 0 immediately. Then restart with syn=1 -> stream begins again at mem[0]; memory intact.
- Basic stream: load mem[0..3]=0x11,0x22,0x33,0x44, len=4, syn held high from cycle 0 -> acks at cycles 2..5 with data 0x11..0x44; last only at cycle 5; ack=0 afterwards; busy=0 one cycle after syn drops.
- Pause/resume: len=4, drop syn for 3 cycles after the second ack -> no ack while syn low; next ack carries 0x33, then 0x44 with last.
- Length boundaries:
  - len=1 -> single ack with last=1 on mem[0].
  - len=0 -> no ack ever, busy stays 0.
  - len=32 with full memory -> 32 acks, last on mem[31].
- Write during stream: wr_en to addr 2 with 0xDEAD while in STREAM -> ignored; word 2 still 0x33. The same write in IDLE is effective on the next stream.
- End-to-end with instruction_fetch: f_i_ce=1, len=5 -> fetch f_o_pc reaches 20, f_o_instr sequence matches memory, syn drops after last, responder returns to IDLE.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the syn/ack/last instruction-streaming handshake.
// The fetch side and the bench use the same state encoding and default sizes.
package stream_pkg;

   localparam int unsigned IWIDTH_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } stream_state_e;

endpackage

// File: rtl/instr_mem.sv
// Program memory: one synchronous write port and one asynchronous read port.
// It has no reset, so its contents survive a reset that aborts a stream.
module instr_mem #(
   parameter int unsigned IWIDTH = 32,
   parameter int unsigned DEPTH  = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [DEPTH-1:0]  wr_addr,
   input  logic [IWIDTH-1:0] wr_data,
   input  logic [DEPTH-1:0]  rd_addr,
   output logic [IWIDTH-1:0] rd_data
);

   logic [IWIDTH-1:0] mem_q [2**DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_stream_responder.sv
// Responder end of the syn/ack/last stream: while syn is high it returns one
// registered program word per cycle, flagging the last word of the program.
module instr_stream_responder
   import stream_pkg::*;
#(
   parameter int unsigned IWIDTH = IWIDTH_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              f_clk,
   input  logic              f_rst,
   input  logic              f_i_syn,
   output logic [IWIDTH-1:0] f_o_instr,
   output logic              f_o_ack,
   output logic              f_o_last,
   input  logic              f_i_wr_en,
   input  logic [DEPTH-1:0]  f_i_wr_addr,
   input  logic [IWIDTH-1:0] f_i_wr_data,
   input  logic [DEPTH:0]    f_i_len,
   output logic              f_o_busy
);

   // Handshake: a word is transferred on each edge where syn is sampled high
   // in STREAM; ack marks the cycle the word is on f_o_instr, last rides with ack.

   localparam logic [DEPTH:0] MAX_LEN = {1'b1, {DEPTH{1'b0}}};
   localparam logic [DEPTH:0] ONE     = {{DEPTH{1'b0}}, 1'b1};

   stream_state_e     state_q, state_d;
   logic [DEPTH:0]    rd_ptr_q, rd_ptr_d;
   logic [DEPTH:0]    len_q, len_d;
   logic [IWIDTH-1:0] instr_q, instr_d;
   logic              ack_q, ack_d;
   logic              last_q, last_d;
   logic [IWIDTH-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic              beat_is_last;

   // Loads are only accepted while no stream is being read out.
   assign mem_wr_en = f_i_wr_en && (state_q != ST_STREAM);

   instr_mem #(
      .IWIDTH (IWIDTH),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (f_clk),
      .wr_en   (mem_wr_en),
      .wr_addr (f_i_wr_addr),
      .wr_data (f_i_wr_data),
      .rd_addr (rd_ptr_q[DEPTH-1:0]),
      .rd_data (mem_rd_data)
   );

   assign beat_is_last = (rd_ptr_q == (len_q - ONE));

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      instr_d  = '0;
      ack_d    = 1'b0;
      last_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (f_i_syn && (f_i_len != '0)) begin
               len_d    = (f_i_len > MAX_LEN) ? MAX_LEN : f_i_len;
               rd_ptr_d = '0;
               state_d  = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (f_i_syn) begin
               instr_d  = mem_rd_data;
               ack_d    = 1'b1;
               last_d   = beat_is_last;
               rd_ptr_d = rd_ptr_q + ONE;
               if (beat_is_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Hold until syn falls so a lagging requester cannot trigger a replay.
            if (!f_i_syn) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge f_clk or negedge f_rst) begin
      if (!f_rst) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= '0;
         len_q    <= '0;
         instr_q  <= '0;
         ack_q    <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         instr_q  <= instr_d;
         ack_q    <= ack_d;
         last_q   <= last_d;
      end
   end

   assign f_o_instr = instr_q;
   assign f_o_ack   = ack_q;
   assign f_o_last  = last_q;
   assign f_o_busy  = (state_q != ST_IDLE);

endmodule
